// File: rtl/mpu_regs_writeback.sv
// Write-back sequencer for mpu_registers: buffers sized register-write requests in an
// in-order FIFO, issues one per enabled cycle, and flags reads of still-pending indices.
module mpu_regs_writeback #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         en,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [IDX_W-1:0]             req_idx,
    input  logic [63:0]                  req_data,
    input  logic [1:0]                   req_size,
    input  logic [2:0]                   req_sel,
    input  logic [2:0]                   req_r_sel,
    output logic                         we,
    output logic [IDX_W-1:0]             w_idx,
    output logic [63:0]                  w_data,
    output logic [1:0]                   w_size,
    output logic [2:0]                   w_sel,
    output logic [2:0]                   w_r_sel,
    input  logic [IDX_W-1:0]             r_idx0,
    input  logic [IDX_W-1:0]             r_idx1,
    input  logic [IDX_W-1:0]             r_idx2,
    input  logic [IDX_W-1:0]             r_idx3,
    output logic                         r_pend0,
    output logic                         r_pend1,
    output logic                         r_pend2,
    output logic                         r_pend3,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [63:0]      data;
        logic [1:0]       size;
        logic [2:0]       sel;
        logic [2:0]       r_sel;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] offs [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [IDX_W-1:0] r_idx [4];
    logic [3:0]       pend;

    // A pop in the same cycle never frees a slot, so a full FIFO always refuses.
    assign req_ready = (count < CNT_W'(DEPTH));
    assign push      = req_valid & req_ready;
    assign pop       = en & (count != '0);
    assign head      = mem[rd_ptr];

    // NOTE: the storage array has no reset; validity comes from rd_ptr/count alone.
    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_idx, req_data, req_size, req_sel, req_r_sel};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            we      <= 1'b0;
            w_idx   <= '0;
            w_data  <= '0;
            w_size  <= '0;
            w_sel   <= '0;
            w_r_sel <= '0;
        end else if (pop) begin
            we      <= 1'b1;
            w_idx   <= head.idx;
            w_data  <= head.data;
            w_size  <= head.size;
            w_sel   <= head.sel;
            w_r_sel <= head.r_sel;
        end else begin
            we <= 1'b0;
        end
    end

    // Slot s is live when its distance from rd_ptr (mod DEPTH) is below the occupancy.
    for (genvar s = 0; s < DEPTH; s++) begin : g_slot
        assign offs[s]       = PTR_W'(s) - rd_ptr;
        assign slot_valid[s] = (CNT_W'(offs[s]) < count);
    end

    assign r_idx[0] = r_idx0;
    assign r_idx[1] = r_idx1;
    assign r_idx[2] = r_idx2;
    assign r_idx[3] = r_idx3;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            pend[p] = we && (w_idx == r_idx[p]);
            for (int s = 0; s < DEPTH; s++) begin
                if (slot_valid[s] && (mem[s].idx == r_idx[p])) pend[p] = 1'b1;
            end
        end
    end

    assign r_pend0 = pend[0];
    assign r_pend1 = pend[1];
    assign r_pend2 = pend[2];
    assign r_pend3 = pend[3];

endmodule

// File: tb/tb_mpu_regs_writeback.sv
// Scoreboard bench for mpu_regs_writeback: accepted requests are queued as expected
// writes and compared against every we cycle, plus directed checks on count/ready/pending.
module tb_mpu_regs_writeback;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        en = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_idx = '0;
    logic [63:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic [2:0]  req_sel = '0;
    logic [2:0]  req_r_sel = '0;
    logic        we;
    logic [4:0]  w_idx;
    logic [63:0] w_data;
    logic [1:0]  w_size;
    logic [2:0]  w_sel;
    logic [2:0]  w_r_sel;
    logic [4:0]  r_idx0 = '0, r_idx1 = 5'd9, r_idx2 = 5'd10, r_idx3 = 5'd11;
    logic        r_pend0, r_pend1, r_pend2, r_pend3;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
        logic [1:0]  size;
        logic [2:0]  sel;
        logic [2:0]  r_sel;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    mpu_regs_writeback #(.DEPTH(4), .IDX_W(5)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_data(req_data), .req_size(req_size),
        .req_sel(req_sel), .req_r_sel(req_r_sel),
        .we(we), .w_idx(w_idx), .w_data(w_data), .w_size(w_size),
        .w_sel(w_sel), .w_r_sel(w_r_sel),
        .r_idx0(r_idx0), .r_idx1(r_idx1), .r_idx2(r_idx2), .r_idx3(r_idx3),
        .r_pend0(r_pend0), .r_pend1(r_pend1), .r_pend2(r_pend2), .r_pend3(r_pend3),
        .count(count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Present a request for the next edge; queue it as expected only if it will be accepted.
    task automatic drive_req(input logic [4:0] idx, input logic [63:0] data,
                             input logic [1:0] size, input logic [2:0] sel,
                             input logic [2:0] r_sel);
        exp_t e;
        req_valid = 1'b1;
        req_idx   = idx;
        req_data  = data;
        req_size  = size;
        req_sel   = sel;
        req_r_sel = r_sel;
        if (req_ready) begin
            e.idx = idx; e.data = data; e.size = size; e.sel = sel; e.r_sel = r_sel;
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor: every issued write must match the oldest accepted request.
    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 64'(we), 64'd0);
            end else begin
                e = sb.pop_front();
                check("sb_idx",   64'(w_idx),   64'(e.idx));
                check("sb_data",  w_data,       e.data);
                check("sb_size",  64'(w_size),  64'(e.size));
                check("sb_sel",   64'(w_sel),   64'(e.sel));
                check("sb_r_sel", 64'(w_r_sel), 64'(e.r_sel));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        sys_rst = 1'b0;
        check("rst_we",    64'(we),        64'd0);
        check("rst_count", 64'(count),     64'd0);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_wdata", w_data,         64'd0);
        check("rst_pend0", 64'(r_pend0),   64'd0);

        // 1. Single write, index 0
        en = 1'b1;
        drive_req(5'd0, 64'haaaaaaaaaaaaaaaa, 2'b11, 3'd0, 3'd0);
        tick();
        req_valid = 1'b0;
        check("t1_count_k",  64'(count),   64'd1);
        check("t1_we_k",     64'(we),      64'd0);
        check("t1_pend0_k",  64'(r_pend0), 64'd1);
        tick();
        check("t1_we",       64'(we),      64'd1);
        check("t1_widx",     64'(w_idx),   64'd0);
        check("t1_wdata",    w_data,       64'haaaaaaaaaaaaaaaa);
        check("t1_count",    64'(count),   64'd0);
        check("t1_pend0_we", 64'(r_pend0), 64'd1);
        tick();
        check("t1_we_off",   64'(we),      64'd0);
        check("t1_pend0_off",64'(r_pend0), 64'd0);

        // 2. Fill and backpressure with drain disabled
        en = 1'b0;
        r_idx1 = 5'd1; r_idx2 = 5'd2; r_idx3 = 5'd3;
        for (int i = 1; i <= 4; i++) begin
            drive_req(5'(i), 64'h100 + 64'(i), 2'b10, 3'(i), 3'(i));
            tick();
        end
        check("t2_count_full", 64'(count),     64'd4);
        check("t2_ready_full", 64'(req_ready), 64'd0);
        drive_req(5'd5, 64'hdead, 2'b00, 3'd0, 3'd0);
        tick();
        req_valid = 1'b0;
        check("t2_count_held", 64'(count),   64'd4);
        check("t2_we_off",     64'(we),      64'd0);
        check("t2_pend1",      64'(r_pend1), 64'd1);
        check("t2_pend2",      64'(r_pend2), 64'd1);
        check("t2_pend3",      64'(r_pend3), 64'd1);
        check("t2_pend0",      64'(r_pend0), 64'd0);
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_drain_we",  64'(we),    64'd1);
            check("t2_drain_idx", 64'(w_idx), 64'(i));
        end
        tick();
        check("t2_we_done",    64'(we),    64'd0);
        check("t2_count_done", 64'(count), 64'd0);

        // 3. Pass-through of sized fields
        drive_req(5'd1, 64'hbbbbbbbbbbbbbbbb, 2'b01, 3'b010, 3'b010);
        tick();
        req_valid = 1'b0;
        tick();
        check("t3_we",    64'(we),      64'd1);
        check("t3_size",  64'(w_size),  64'd1);
        check("t3_sel",   64'(w_sel),   64'd2);
        check("t3_r_sel", 64'(w_r_sel), 64'd2);
        check("t3_data",  w_data,       64'hbbbbbbbbbbbbbbbb);
        tick();

        // 4. Simultaneous push and pop across pointer wrap
        en = 1'b0;
        drive_req(5'd20, 64'h10, 2'b11, 3'd0, 3'd0);
        tick();
        drive_req(5'd20, 64'h11, 2'b11, 3'd0, 3'd0);
        tick();
        check("t4_count_pre", 64'(count), 64'd2);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_req(5'd20, 64'h12 + 64'(i), 2'b11, 3'd0, 3'd0);
            tick();
            check("t4_count", 64'(count), 64'd2);
            check("t4_we",    64'(we),    64'd1);
            check("t4_data",  w_data,     64'h10 + 64'(i));
        end
        req_valid = 1'b0;
        tick();
        check("t4_data_tail0", w_data, 64'h16);
        tick();
        check("t4_data_tail1", w_data, 64'h17);
        tick();
        check("t4_we_done", 64'(we), 64'd0);

        // 5. Reset mid-stream
        en = 1'b0;
        r_idx0 = 5'd12; r_idx1 = 5'd13; r_idx2 = 5'd14; r_idx3 = 5'd15;
        for (int i = 0; i < 4; i++) begin
            drive_req(5'(12 + i), 64'h5500 + 64'(i), 2'b10, 3'd3, 3'd1);
            tick();
        end
        req_valid = 1'b0;
        en = 1'b1;
        tick();
        check("t5_count_pre", 64'(count),   64'd3);
        check("t5_we_pre",    64'(we),      64'd1);
        check("t5_pend3_pre", 64'(r_pend3), 64'd1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        sb.delete();
        check("t5_we",     64'(we),        64'd0);
        check("t5_count",  64'(count),     64'd0);
        check("t5_ready",  64'(req_ready), 64'd1);
        check("t5_pend",   64'({r_pend0, r_pend1, r_pend2, r_pend3}), 64'd0);
        check("t5_widx",   64'(w_idx),     64'd0);
        check("t5_wdata",  w_data,         64'd0);
        check("t5_wsize",  64'(w_size),    64'd0);
        check("t5_wsel",   64'(w_sel),     64'd0);
        check("t5_wrsel",  64'(w_r_sel),   64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_stale", 64'(we), 64'd0);
        end

        // 6. Pending on a single entry through its write cycle
        r_idx0 = 5'd0; r_idx1 = 5'd1; r_idx2 = 5'd7; r_idx3 = 5'd3;
        drive_req(5'd7, 64'h77, 2'b11, 3'd0, 3'd0);
        tick();
        req_valid = 1'b0;
        check("t6_pend2_fifo",  64'(r_pend2), 64'd1);
        check("t6_others_fifo", 64'({r_pend0, r_pend1, r_pend3}), 64'd0);
        tick();
        check("t6_we",          64'(we),      64'd1);
        check("t6_pend2_we",    64'(r_pend2), 64'd1);
        check("t6_others_we",   64'({r_pend0, r_pend1, r_pend3}), 64'd0);
        tick();
        check("t6_pend2_after", 64'(r_pend2), 64'd0);
        check("t6_others_after",64'({r_pend0, r_pend1, r_pend3}), 64'd0);

        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpu_regs_writeback.md
Name: mpu_regs_writeback

Overview:
- Write-back sequencer that owns the write port of mpu_registers.
- Accepts sized register-write requests from MPU execution units over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains one entry per enabled cycle onto we/w_idx/w_data/w_size/w_sel/w_r_sel.
- Reports, per read port, whether a write to that port's register index is still pending, so the decoder can stall operand reads.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- IDX_W, 5, register index width.

Ports:
- sys_clk  input  1  system clock; all state changes on the rising edge.
- sys_rst  input  1  reset, synchronous and active-high.
- en  input  1  drain enable; the FIFO pops only while en=1.
- req_valid  input  1  write request present.
- req_ready  output  1  FIFO can accept a request.
- req_idx  input  IDX_W  destination register index.
- req_data  input  64  source data.
- req_size  input  2  chunk width: 00=8, 01=16, 10=32, 11=64 bits.
- req_sel  input  3  destination chunk index.
- req_r_sel  input  3  source chunk index within req_data.
- we  output  1  register-file write strobe.
- w_idx  output  IDX_W  write index.
- w_data  output  64  write data.
- w_size  output  2  write size.
- w_sel  output  3  destination chunk select.
- w_r_sel  output  3  source chunk select.
- r_idx0..r_idx3  input  IDX_W each  read indices, mirrored from the register-file read ports.
- r_pend0..r_pend3  output  1 each  a write to r_idxN is buffered or being issued.
- count  output  clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset: on a rising edge with sys_rst=1, the FIFO empties, count=0, we=0, and w_idx/w_data/w_size/w_sel/w_r_sel all become 0.
- Reset mid-operation discards every buffered and in-flight write; no we pulse occurs in the cycle following reset.
- req_ready = (count < DEPTH). It is combinational from count only. A pop in the same cycle does not make room, so a full FIFO never accepts a request.
- Push: at each edge with req_valid & req_ready, the entry {idx,data,size,sel,r_sel} is written at wr_ptr and wr_ptr increments modulo DEPTH.
- Pop: at each edge with en=1 & count>0 & !sys_rst:
  - the entry at rd_ptr loads the output registers;
  - we<=1;
  - rd_ptr increments modulo DEPTH.
- No pop: at each edge where the pop condition is false, we<=0 and the w_* outputs hold their last values.
- No fall-through: a request pushed at edge k into an empty FIFO is popped at edge k+1 at the earliest, so we=1 during the cycle after edge k+1.
- Order: pops are strictly in acceptance order.
- Throughput: one write per cycle sustained.
- count: the next value is count + push - pop. A simultaneous push and pop leaves count unchanged.
- Wrap-around: DEPTH is a power of two, so pointer wrap is natural overflow of a clog2(DEPTH)-bit pointer.
- Pass-through: size, sel and r_sel are passed through unmodified. The block does not check whether a chunk index is legal.
- Pending flags: r_pendN is combinational. It is 1 iff either:
  - (we=1 and w_idx==r_idxN), or
  - any valid FIFO entry has idx==r_idxN.
- Entry validity: an entry is valid when its slot lies in [rd_ptr, rd_ptr+count) modulo DEPTH.
- Pending flags apply equally to register index 0.
- en=0: no pop and we drops at the next edge. Pushes continue until full. r_pend stays asserted for all buffered indices.

Test Plan:
1. Single write: after reset, push idx=0, data=0xaaaaaaaaaaaaaaaa, size=11, sel=0, r_sel=0 at edge k, with en=1.
   -> we=1 for exactly one cycle after edge k+1, with w_idx=0 and w_data=0xaaaaaaaaaaaaaaaa.
   -> count returns to 0.
   -> r_pend0=1 from edge k through the we cycle; 0 afterwards.
2. Fill/backpressure: en=0, push idx 1,2,3,4.
   -> count=4, req_ready=0.
   -> a fifth request is held: no change to count or FIFO contents.
   -> r_pend1..3=1 with r_idx1..3=1..3.
   Then set en=1.
   -> four consecutive we cycles with w_idx=1,2,3,4 in order.
3. Pass-through of sized fields: push idx=1, data=0xbbbbbbbbbbbbbbbb, size=01, sel=010, r_sel=010.
   -> w_size=01, w_sel=010, w_r_sel=010, w_data=0xbbbbbbbbbbbbbbbb while we=1.
4. Simultaneous push and pop: with count=2 and en=1, push every cycle for 6 cycles.
   -> count stays 2 throughout.
   -> we=1 every cycle.
   -> data is issued in push order across pointer wrap (push data 0x10..0x17, issue 0x10..0x17).
5. Reset mid-stream: with count=3 and we=1, assert sys_rst for one edge.
   -> next cycle: we=0, count=0, req_ready=1, all r_pend=0, all w_* outputs=0.
   -> no stale entries are issued afterwards.
6. Pending on the in-flight write only: push idx=7 and hold r_idx2=7.
   -> r_pend2=1 while the entry is in the FIFO and during its we cycle.
   -> r_pend2=0 in the cycle after its we cycle; r_pend0/1/3=0 throughout (their indices differ).
